// File: rtl/mbox_store_buf.sv
// mbox_store_buf: posted-write buffer between the EBOX datapath and the MBOX
// memory port. Stores are queued in a circular array and drained to memory in
// order over a req/ack handshake. Loads that hit a pending store see the youngest
// matching word. A flush request blocks new stores until the buffer is empty.
//
// Optional build macro: KL10_STOREBUF_PARITY_EN
//   defined   - each entry keeps an odd-parity bit computed at push time, and
//               memParity reports the head entry's bit.
//   undefined - no parity storage; memParity is tied to 0.
module mbox_store_buf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     eboxClk,
    input  logic                     eboxReset,
    input  logic                     storeReq,
    input  logic [13:35]             storeAdr,
    input  logic [0:35]              storeData,
    output logic                     storeReady,
    output logic                     memReq,
    output logic [13:35]             memAdr,
    output logic [0:35]              memData,
    output logic                     memParity,
    input  logic                     memAck,
    input  logic [13:35]             loadAdr,
    output logic                     loadHit,
    output logic [0:35]              loadData,
    input  logic                     flushReq,
    output logic                     flushDone,
    output logic [$clog2(DEPTH):0]   bufCount
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef enum logic {StIdle, StFlush} state_e;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic [13:35] adr_mem  [DEPTH];
    logic [0:35]  data_mem [DEPTH];

    ptr_t   wp_q, rp_q;
    cnt_t   count_q, count_d;
    state_e state_q;
    logic   done_q;
    logic   push, pop;
    ptr_t   idx;

    assign storeReady = (count_q != FULL) && (state_q == StIdle);
    assign memReq     = (count_q != '0);
    assign push       = storeReq && storeReady;
    assign pop        = memAck && memReq;
    assign bufCount   = count_q;
    assign flushDone  = done_q;

    // Head entry; outputs read as zero while the buffer is empty so stale
    // entries left behind by reset never reach the memory port.
    assign memAdr  = memReq ? adr_mem[rp_q]  : '0;
    assign memData = memReq ? data_mem[rp_q] : '0;

    // Occupancy after this edge: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + ptr_t'(1);
            if (pop)  rp_q <= rp_q + ptr_t'(1);
            count_q <= count_d;
        end
    end

    // Entry storage; not reset, entries are unreachable once the buffer is empty.
    always_ff @(posedge eboxClk) begin
        if (push) begin
            adr_mem[wp_q]  <= storeAdr;
            data_mem[wp_q] <= storeData;
        end
    end

`ifdef KL10_STOREBUF_PARITY_EN
    logic par_mem [DEPTH];

    // Odd parity captured alongside each entry at push time.
    always_ff @(posedge eboxClk) begin
        if (push) par_mem[wp_q] <= ~^storeData;
    end

    assign memParity = memReq & par_mem[rp_q];
`else
    assign memParity = 1'b0;
`endif

    // Flush sequencer: leave FLUSH, pulsing done, once the buffer is empty.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (flushReq) state_q <= StFlush;
                end
                StFlush: begin
                    if (count_d == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Load forwarding: walk oldest to youngest so the youngest match wins.
    // Uses the pre-edge occupancy, so an entry popped this cycle still hits and
    // one pushed this cycle does not.
    always_comb begin
        loadHit  = 1'b0;
        loadData = '0;
        idx      = rp_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rp_q + ptr_t'(i);
            if ((cnt_t'(i) < count_q) && (adr_mem[idx] == loadAdr)) begin
                loadHit  = 1'b1;
                loadData = data_mem[idx];
            end
        end
    end

endmodule

// File: doc/mbox_store_buf.md
# mbox_store_buf

Posted-write buffer between the EBOX datapath and the MBOX memory port. Captures store words (36-bit AR contents plus a 23-bit physical address) in a small FIFO so the EBOX can continue without waiting on memory. Drains entries to memory in order over a req/ack handshake. Forwards buffered data to loads that hit a pending store, and supports an explicit flush used before diagnostic reads and page-table changes.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.

Ports:
- eboxClk  in  1  sole clock; all state changes on its rising edge.
- eboxReset  in  1  synchronous, active-high reset.
- storeReq  in  1  push request; a push occurs in a cycle where storeReq && storeReady.
- storeAdr  in  [13:35]  physical address of store.
- storeData  in  [0:35]  store word (EDP_AR).
- storeReady  out  1  buffer will accept a push this cycle.
- memReq  out  1  head entry valid and presented to memory.
- memAdr  out  [13:35]  head entry address.
- memData  out  [0:35]  head entry data.
- memParity  out  1  odd parity of memData (see Configuration).
- memAck  in  1  memory has taken the head entry; pops it.
- loadAdr  in  [13:35]  address of a load being issued.
- loadHit  out  1  some valid entry matches loadAdr.
- loadData  out  [0:35]  data of youngest matching entry.
- flushReq  in  1  one-cycle request to drain the buffer.
- flushDone  out  1  one-cycle pulse when a flush has completed.
- bufCount  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: circular array of DEPTH entries {adr, data[, par]}, write pointer wp, read pointer rp, count; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: entry[wp] <= {storeAdr, storeData}; wp increments; count increments.
- Pop: on memAck && memReq, rp increments; count decrements. memAck while memReq=0 is ignored.
- Simultaneous push and pop: both happen; count unchanged.
- storeReady = (count != DEPTH) && (state == IDLE). A memAck arriving in the same cycle does not make a full buffer ready; the push must wait one cycle.
- memReq = (count != 0); memAdr/memData = entry[rp]. These are register outputs and stay stable while memReq=1 and memAck=0.
- Forwarding is combinational. Scan the valid entries from youngest (wp-1) to oldest (rp); the first one with adr == loadAdr drives loadData. loadHit=0 forces loadData=0. A store being pushed in the current cycle is not visible. An entry popped in the current cycle is still visible.
- State machine, two states:
  - IDLE: flushReq -> FLUSH.
  - FLUSH: storeReady=0; draining continues; when count==0, pulse flushDone for one cycle and return to IDLE.
  - flushReq while already in FLUSH is ignored.
  - flushReq with an empty buffer: FLUSH for one cycle, then flushDone.
- Reset: clears wp, rp, count and state to IDLE. Entry contents are not cleared; they are unreachable once the buffer is empty. An in-flight memReq is dropped, and the memory side must tolerate this.

## Timing
- Reset values: storeReady=1, memReq=0, memAdr=0, memData=0, memParity=0, loadHit=0, loadData=0, flushDone=0, bufCount=0.
- Push-to-memReq latency: 1 cycle. A push at edge N gives memReq=1 after edge N.
- Back-to-back drain: memAck every cycle pops one entry per cycle; memReq stays high while count>0.
- flushReq sampled at edge N: state=FLUSH after N. flushDone is high in the cycle after the edge at which count reaches 0 and state is FLUSH; it drops after the next edge.
- bufCount reflects the state after the most recent edge.

## Configuration
- KL10_STOREBUF_PARITY_EN
  - Defined: each entry stores par = ~^storeData, computed at push. memParity = stored par of the head entry.
  - Undefined: no parity storage; memParity tied to 0.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then push adr=0o100, data=0o123456701234 with memAck=0 -> next cycle memReq=1, memAdr=0o100, memData=0o123456701234, bufCount=1; held 5 cycles unchanged.
- DEPTH=4, push 4 words with no ack -> storeReady=0, bufCount=4. Assert memAck and storeReq in the same cycle -> no push; next cycle storeReady=1, bufCount=3.
- Push adr 0o200 data=1, then adr 0o200 data=2, then adr 0o201 data=3; loadAdr=0o200 -> loadHit=1, loadData=2. loadAdr=0o202 -> loadHit=0, loadData=0.
- Push 3 words, pulse flushReq, hold memAck=1 -> storeReady=0 during the drain; pops on 3 consecutive cycles; flushDone pulses once; state returns to IDLE with storeReady=1.
- Wrap-around: 10 push/pop cycles with DEPTH=4 -> memData order matches push order; pointers wrap with no lost or duplicated words.
- Reset asserted with 2 entries pending -> next cycle memReq=0, bufCount=0, storeReady=1. Parity build: push data=0o000000000001 -> memParity=0; data=0 -> memParity=1.
